// File: rtl/bcd_conv_arbiter_pkg.sv
// rtl/bcd_conv_arbiter_pkg.sv - shared types and constants for the BCD converter arbiter
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    ACK
  } state_t;

  localparam int BCD_W       = 16;
  localparam int TIMEOUT_CYC = 32;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// rtl/bcd_conv_arbiter_if.sv - requester-side bus of the BCD converter arbiter
interface bcd_conv_arbiter_if
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_W = 13
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][BIN_W-1:0] bin_in;
  logic [N_REQ-1:0]            ack;
  logic [BCD_W-1:0]            bcd_out;
  logic [ID_W-1:0]             grant_id;
  logic                        busy;
  logic                        err;

  // Requesters drive requests and operands, receive results.
  modport master (
    output req, bin_in,
    input  ack, bcd_out, grant_id, busy, err
  );

  // The arbiter receives requests and returns results.
  modport slave (
    input  req, bin_in,
    output ack, bcd_out, grant_id, busy, err
  );

endinterface

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// rtl/bcd_conv_arbiter_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] idx;
  logic            found;

  // Walk the requesters from last_grant+1 with wrap; the first active one wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = last_grant;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - shares one binary-to-BCD converter among requesters; optional watchdog via BCD_ARB_TIMEOUT_EN
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  bcd_conv_arbiter_if.slave bus,
  output logic             conv_start,
  output logic [BIN_W-1:0] conv_bin,
  input  logic             conv_ready,
  input  logic             conv_done_tick,
  input  logic [3:0]       conv_bcd3,
  input  logic [3:0]       conv_bcd2,
  input  logic [3:0]       conv_bcd1,
  input  logic [3:0]       conv_bcd0
);

  localparam int ID_W = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [BIN_W-1:0] operand_q, operand_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_id;
  logic [BIN_W-1:0] arb_bin;

`ifdef BCD_ARB_TIMEOUT_EN
  logic [5:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;
`endif

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req       (bus.req),
    .last_grant(last_grant_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id)
  );

  // One-hot AND-OR select of the winning requester's operand.
  always_comb begin
    arb_bin = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_bin = arb_bin | bus.bin_in[i];
      end
    end
  end

  // State and datapath registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      operand_q    <= '0;
      bcd_q        <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      operand_q    <= operand_d;
      bcd_q        <= bcd_d;
`ifdef BCD_ARB_TIMEOUT_EN
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Next-state logic: arbitrate only in IDLE, one start pulse, wait for done, one ack.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    operand_d    = operand_q;
    bcd_d        = bcd_q;
`ifdef BCD_ARB_TIMEOUT_EN
    wdog_d       = wdog_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if ((|bus.req) && conv_ready) begin
          grant_id_d = arb_id;
          operand_d  = arb_bin;
          state_d    = START;
        end
      end
      START: begin
        state_d = WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
        wdog_d    = '0;
        timeout_d = 1'b0;
`endif
      end
      WAIT: begin
        if (conv_done_tick) begin
          bcd_d   = {conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0};
          state_d = ACK;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        else if (wdog_q == 6'(TIMEOUT_CYC - 1)) begin
          bcd_d     = '0;
          timeout_d = 1'b1;
          state_d   = ACK;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      ACK: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Acknowledge decoded from state so reset clears it immediately.
  always_comb begin
    bus.ack = '0;
    if (state_q == ACK) begin
      bus.ack[grant_id_q] = 1'b1;
    end
  end

  assign conv_start   = (state_q == START);
  assign conv_bin     = operand_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q != IDLE);
`ifdef BCD_ARB_TIMEOUT_EN
  assign bus.err      = (state_q == ACK) && timeout_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - scoreboard bench for bcd_conv_arbiter with a converter stub
module tb_bcd_conv_arbiter;

  localparam int N_REQ = 4;
  localparam int BIN_W = 13;

  typedef struct {
    int          id;
    logic [15:0] bcd;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;

  logic             conv_start;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_ready;
  logic             conv_done_tick;
  logic [3:0]       conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0;

  bcd_conv_arbiter_if #(.N_REQ(N_REQ), .BIN_W(BIN_W)) bus ();

  bcd_conv_arbiter #(.N_REQ(N_REQ), .BIN_W(BIN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .conv_start    (conv_start),
    .conv_bin      (conv_bin),
    .conv_ready    (conv_ready),
    .conv_done_tick(conv_done_tick),
    .conv_bcd3     (conv_bcd3),
    .conv_bcd2     (conv_bcd2),
    .conv_bcd1     (conv_bcd1),
    .conv_bcd0     (conv_bcd0)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   model_last;
  logic [15:0] model_bcd;

  logic [N_REQ-1:0] req_set;
  logic [N_REQ-1:0] hold;
  int   base[N_REQ]    = '{default: 0};
  int   ack_cnt[N_REQ] = '{default: 0};

  logic        mute;
  logic        extra_tick;
  logic        stub_run = 1'b0;
  int          stub_cnt = 0;
  logic [12:0] stub_val = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter stub: 13 busy cycles after start, then a done pulse; never reset.
  always @(posedge clk) begin
    if (conv_start) begin
      stub_run <= 1'b1;
      stub_cnt <= 0;
      stub_val <= conv_bin;
    end else if (stub_run) begin
      if (stub_cnt == 13) stub_run <= 1'b0;
      else stub_cnt <= stub_cnt + 1;
    end
  end
  assign conv_ready     = !stub_run;
  assign conv_done_tick = (stub_run && stub_cnt == 13 && !mute) || extra_tick;
  assign conv_bcd3 = 4'((int'(stub_val) / 1000) % 10);
  assign conv_bcd2 = 4'((int'(stub_val) / 100) % 10);
  assign conv_bcd1 = 4'((int'(stub_val) / 10) % 10);
  assign conv_bcd0 = 4'(int'(stub_val) % 10);

  // A request stays up until its ack arrives, unless held.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.req[i] = req_set[i] && (hold[i] || ack_cnt[i] == base[i]);
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int next_winner(logic [N_REQ-1:0] set, int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (set[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  // Monitor: every ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.ack != '0) begin
      chk("ack_onehot", $countones(bus.ack), 1);
      for (int i = 0; i < N_REQ; i++) if (bus.ack[i]) ack_cnt[i]++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ack), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_id", 32'(bus.ack), 32'(1) << e.id);
        chk("grant_id", 32'(bus.grant_id), e.id);
        chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
        chk("err", 32'(bus.err), 32'(e.err));
        if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
      end
    end else if (!rst && bus.err) begin
      chk("err_without_ack", 32'(bus.err), 0);
    end
  end

  task automatic raise(int i, int op);
    bus.bin_in[i] = BIN_W'(op);
    base[i]       = ack_cnt[i];
    req_set[i]    = 1'b1;
  endtask

  task automatic issue_batch(input logic [N_REQ-1:0] mask, input int ops[N_REQ], input bit timed);
    logic [N_REQ-1:0] left;
    int w;
    int k;
    left = mask;
    k = 0;
    while (left != '0) begin
      w = next_winner(left, model_last);
      sb.push_back('{w, to_bcd(ops[w]), 1'b0, timed ? cyc + 16 + 17 * k : -1});
      left[w]    = 1'b0;
      model_last = w;
      model_bcd  = to_bcd(ops[w]);
      k++;
    end
    for (int i = 0; i < N_REQ; i++) if (mask[i]) raise(i, ops[i]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ops[N_REQ];
    int c, w, saved;
    logic [N_REQ-1:0] mask;

    rst = 1'b1; req_set = '0; hold = '0; mute = 1'b0; extra_tick = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_bcd", 32'(bus.bcd_out), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_start", 32'(conv_start), 0);
    chk("rst_bin", 32'(conv_bin), 0);
    rst = 1'b0;
    model_last = N_REQ - 1;
    @(negedge clk);

    // All four at once, fresh priority.
    ops = '{1, 22, 333, 8191};
    issue_batch(4'hF, ops, 1'b1);
    wait_drain();

    // Done tick while idle is ignored.
    extra_tick = 1'b1;
    @(negedge clk);
    extra_tick = 1'b0;
    @(negedge clk);
    chk("stray_tick_bcd", 32'(bus.bcd_out), 32'(model_bcd));
    chk("stray_tick_busy", 32'(bus.busy), 0);

    // Single request, latency 16.
    ops = '{4095, 0, 0, 0};
    issue_batch(4'b0001, ops, 1'b1);
    wait_drain();

    // Fairness: 2 held, 3 raised mid-service.
    ops = '{0, 0, 1357, 2468};
    c = cyc;
    hold[2] = 1'b1;
    raise(2, ops[2]);
    w = next_winner(4'b0100, model_last);
    sb.push_back('{w, to_bcd(ops[w]), 1'b0, c + 16}); model_last = w;
    repeat (8) @(negedge clk);
    raise(3, ops[3]);
    w = next_winner(4'b1100, model_last);
    sb.push_back('{w, to_bcd(ops[w]), 1'b0, c + 33}); model_last = w;
    w = next_winner(4'b1100 & ~(4'b0001 << w), model_last);
    sb.push_back('{w, to_bcd(ops[w]), 1'b0, c + 50}); model_last = w;
    while (cyc < c + 34) @(negedge clk);
    hold[2] = 1'b0;
    base[2] = ack_cnt[2];
    wait_drain();

    // Withdrawal of requester 1 while 0 is served.
    saved = ack_cnt[1];
    ops = '{777, 0, 0, 0};
    issue_batch(4'b0001, ops, 1'b1);
    repeat (3) @(negedge clk);
    raise(1, 5);
    repeat (3) @(negedge clk);
    req_set[1] = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);
    chk("withdraw_no_ack", ack_cnt[1], saved);

    // Async reset during WAIT.
    raise(2, 4321);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_ack", 32'(bus.ack), 0);
    chk("arst_start", 32'(conv_start), 0);
    chk("arst_bin", 32'(conv_bin), 0);
    chk("arst_bcd", 32'(bus.bcd_out), 0);
    chk("arst_grant", 32'(bus.grant_id), 0);
    chk("arst_err", 32'(bus.err), 0);
    req_set = '0;
    @(negedge clk);
    rst = 1'b0;
    model_last = N_REQ - 1;
    ops = '{0, 0, 0, 0};
    issue_batch(4'b0001, ops, 1'b0);
    wait_drain();

`ifdef BCD_ARB_TIMEOUT_EN
    // Converter never finishes: watchdog forces an erroring ack.
    mute = 1'b1;
    c = cyc;
    raise(1, 55);
    w = next_winner(4'b0010, model_last);
    sb.push_back('{w, 16'h0000, 1'b1, c + 34}); model_last = w;
    wait_drain();
    mute = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // Random batches.
    for (int b = 0; b < 8; b++) begin
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) ops[i] = int'($urandom_range(0, 8191));
      issue_batch(mask, ops, 1'b1);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

endmodule
